clk_div_ctrl: RTL and testbench

- Parametrised successor to the board's fixed divide-by-2 system clock divider.
- Divides clk by a runtime-programmable ratio N and produces:
  - a registered divided clock, clk_out;
  - a one-cycle enable pulse, tick, aligned to each clk_out rising edge.
- Supports run, halt and single-step modes so the 32-bit CPU on the board can be stepped from a push-button.
- Sits between the board oscillator and the CPU clock/enable inputs.

---
 rtl/clk_div_ctrl_if.sv | 31 +++
 rtl/clk_div_ctrl.sv | 156 +++++++++++++++
 tb/tb_clk_div_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: control/status bundle for the programmable clock divider.
//   div      : requested divide ratio N (0 and 1 behave as 2)
//   mode     : 00 run, 01 halt, 10 step, 11 run
//   step_btn : raw asynchronous step push-button, active-high
//   clk_out  : registered divided clock
//   tick     : one-clk pulse in the cycle clk_out rises
//   running  : high while the period counter is advancing
//   tick_cnt : free-running, wrapping count of tick pulses
// master = board/CPU side driving the controls, slave = the divider.
interface clk_div_ctrl_if #(
    parameter int DIV_W  = 16,
    parameter int TCNT_W = 32
);
    logic [DIV_W-1:0]  div;
    logic [1:0]        mode;
    logic              step_btn;
    logic              clk_out;
    logic              tick;
    logic              running;
    logic [TCNT_W-1:0] tick_cnt;

    modport master (
        output div, mode, step_btn,
        input  clk_out, tick, running, tick_cnt
    );

    modport slave (
        input  div, mode, step_btn,
        output clk_out, tick, running, tick_cnt
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with run/halt/single-step.
// Divides clk by N (clamped to >= 2). clk_out is low for floor(N/2) and high
// for ceil(N/2) cycles; tick pulses for one clk as clk_out goes 0->1.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : clk_div_ctrl_if.slave (div, mode, step_btn in;
//           clk_out, tick, running, tick_cnt out)
// Interface DIV_W/TCNT_W must match the module parameters.
module clk_div_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int TCNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    clk_div_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOP,
        ST_STEP
    } state_t;

    localparam logic [DIV_W-1:0] N_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] N_RST = (DEFAULT_DIV < 2) ? N_MIN : DIV_W'(DEFAULT_DIV);

    state_t            state;
    state_t            state_nxt;

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_nxt;
    logic [DIV_W-1:0]  n_eff;
    logic [DIV_W-1:0]  half;
    logic [DIV_W-1:0]  div_clamped;
    logic              wrap;
    logic              advance;
    logic              mode_run;
    logic              mode_step;

    logic              clk_out_r;
    logic              tick_r;
    logic [TCNT_W-1:0] tick_cnt_r;

    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              step_pulse;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    always_comb begin
        mode_run    = (bus.mode == 2'b00) || (bus.mode == 2'b11);
        mode_step   = (bus.mode == 2'b10);
        advance     = (state != ST_STOP);
        half        = n_eff >> 1;
        wrap        = (cnt == n_eff - DIV_W'(1));
        cnt_nxt     = wrap ? '0 : cnt + DIV_W'(1);
        div_clamped = (bus.div < N_MIN) ? N_MIN : bus.div;
        // Rising edge of the synchronised button; a held button gives one pulse.
        step_pulse  = sync2 & ~sync3;
    end

    // ------------------------------------------------------------------
    // Step button: two-flop synchroniser plus edge-detect flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.step_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. Leaving RUN or STEP only happens on the period
    // boundary, so a halt always parks at cnt=0 with clk_out low and a
    // step always completes a whole period. Button pulses outside STOP
    // are simply not looked at, hence never queued.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (!mode_run && wrap) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mode_run) begin
                    state_nxt = ST_RUN;
                end else if (mode_step && step_pulse) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (wrap) begin
                    state_nxt = mode_run ? ST_RUN : ST_STOP;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Period counter and outputs. clk_out/tick are decoded from the
    // next count so they are registered yet line up with that count.
    // The ratio is only reloaded on the boundary edge, so a div change
    // can never shorten the period in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            n_eff      <= N_RST;
            clk_out_r  <= 1'b0;
            tick_r     <= 1'b0;
            tick_cnt_r <= '0;
        end else begin
            tick_r <= 1'b0;
            if (advance) begin
                cnt       <= cnt_nxt;
                clk_out_r <= (cnt_nxt >= half);
                tick_r    <= (cnt_nxt == half);
                if (cnt_nxt == half) begin
                    tick_cnt_r <= tick_cnt_r + TCNT_W'(1);
                end
                if (wrap) begin
                    n_eff <= div_clamped;
                end
            end
        end
    end

    assign bus.clk_out  = clk_out_r;
    assign bus.tick     = tick_r;
    assign bus.tick_cnt = tick_cnt_r;
    assign bus.running  = (state != ST_STOP);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed scenarios plus randomized traffic for
// clk_div_ctrl, checked every cycle against a period/position model.
module tb_clk_div_ctrl;

    localparam int TB_DIV_W  = 16;
    localparam int TB_TCNT_W = 4;
    localparam int TB_DEFDIV = 2;

    logic                clk;
    logic                t_reset;
    logic [TB_DIV_W-1:0] t_div;
    logic [1:0]          t_mode;
    logic                t_btn;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    clk_div_ctrl_if #(.DIV_W(TB_DIV_W), .TCNT_W(TB_TCNT_W)) bus ();

    assign bus.div      = t_div;
    assign bus.mode     = t_mode;
    assign bus.step_btn = t_btn;

    clk_div_ctrl #(
        .DIV_W      (TB_DIV_W),
        .DEFAULT_DIV(TB_DEFDIV),
        .TCNT_W     (TB_TCNT_W)
    ) dut (
        .clk  (clk),
        .reset(t_reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Position within the current period, the period length in force,
    // and whether the divider is parked / doing a single-step period.
    int unsigned m_pos;
    int unsigned m_n;
    bit          m_parked;
    bit          m_single;
    bit          m_clk;
    bit          m_tick;
    int unsigned m_tcnt;
    bit          b1, b2, b3;   // button as sampled 1, 2, 3 edges ago

    function automatic int unsigned clamp_n(input int unsigned d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_pos    = 0;
        m_n      = clamp_n(TB_DEFDIV);
        m_parked = 0;
        m_single = 0;
        m_clk    = 0;
        m_tick   = 0;
        m_tcnt   = 0;
        b1 = 0; b2 = 0; b3 = 0;
    endtask

    task automatic model_edge();
        bit          pulse;
        bit          is_run;
        int unsigned nxt;
        // A press is seen three edges after the button rises.
        pulse  = b2 & ~b3;
        b3 = b2; b2 = b1; b1 = t_btn;
        is_run = (t_mode == 2'd0) || (t_mode == 2'd3);
        m_tick = 0;
        if (!m_parked) begin
            nxt    = (m_pos + 1) % m_n;
            m_tick = (nxt == m_n / 2);
            m_clk  = (nxt >= m_n / 2);
            if (m_tick) m_tcnt = (m_tcnt + 1) % (1 << TB_TCNT_W);
            m_pos = nxt;
            if (nxt == 0) begin
                m_n = clamp_n(t_div);
                if (m_single) begin
                    m_parked = !is_run;
                    m_single = 0;
                end else begin
                    m_parked = !is_run;
                end
            end
        end else begin
            if (is_run) begin
                m_parked = 0;
            end else if (t_mode == 2'd2 && pulse) begin
                m_parked = 0;
                m_single = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clk edge: advance model at the edge, compare on the falling edge.
    task automatic do_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("clk_out",  {31'd0, bus.clk_out}, {31'd0, m_clk});
        check_val("tick",     {31'd0, bus.tick},    {31'd0, m_tick});
        check_val("running",  {31'd0, bus.running}, {31'd0, !m_parked});
        check_val("tick_cnt", 32'(bus.tick_cnt),    m_tcnt);
    endtask

    // Async reset pulse between clock edges; checked before any edge.
    task automatic apply_reset();
        t_reset = 1'b1;
        #1;
        model_reset();
        check_val("rst_clk_out",  {31'd0, bus.clk_out}, 32'd0);
        check_val("rst_tick",     {31'd0, bus.tick},    32'd0);
        check_val("rst_tick_cnt", 32'(bus.tick_cnt),    32'd0);
        check_val("rst_running",  {31'd0, bus.running}, 32'd1);
        #1;
        t_reset = 1'b0;
    endtask

    // Edges until the next observed tick (bounded).
    task automatic wait_tick(output int unsigned edges);
        edges = 0;
        do begin
            do_cycle();
            edges++;
        end while (bus.tick !== 1'b1 && edges < 64);
    endtask

    task automatic wait_pos(input int unsigned pos, input int unsigned n);
        int unsigned k;
        k = 0;
        while (!(m_pos == pos && m_n == n && !m_parked) && k < 64) begin
            do_cycle();
            k++;
        end
        if (k >= 64) check_val("wait_pos", m_pos, pos);
    endtask

    initial begin
        int unsigned e;
        int unsigned k;
        int unsigned ticks;
        int unsigned runs;

        t_reset = 1'b0;
        t_div   = 16'd2;
        t_mode  = 2'd0;
        t_btn   = 1'b0;
        #1 t_reset = 1'b1;
        @(negedge clk);
        apply_reset();

        // 1: N=2 reproduces the old divide-by-2
        for (int i = 1; i <= 10; i++) begin
            do_cycle();
            check_val("s1_clk", {31'd0, bus.clk_out}, 32'(i % 2));
        end
        check_val("s1_tick_cnt", 32'(bus.tick_cnt), 32'd5);

        // 2: N=5, then change to 3 mid-period
        t_div = 16'd5;
        wait_pos(1, 5);
        wait_tick(e); check_val("s2_first", e, 1);
        wait_tick(e); check_val("s2_period5", e, 5);
        wait_pos(1, 5);
        t_div = 16'd3;
        wait_tick(e); check_val("s2_cur_tick", e, 1);
        wait_tick(e); check_val("s2_change", e, 4);
        wait_tick(e); check_val("s2_period3", e, 3);

        // 3: div 0 and 1 behave as 2
        t_div = 16'd0;
        wait_tick(e);
        wait_tick(e); check_val("s3_div0_a", e, 2);
        wait_tick(e); check_val("s3_div0_b", e, 2);
        t_div = 16'd1;
        wait_tick(e);
        wait_tick(e); check_val("s3_div1_a", e, 2);
        wait_tick(e); check_val("s3_div1_b", e, 2);

        // 4: halt at cnt=1 parks after finishing the period
        t_div = 16'd4;
        wait_pos(1, 4);
        t_mode = 2'd1;
        k = 0;
        do begin
            do_cycle();
            k++;
        end while (bus.running !== 1'b0 && k < 20);
        check_val("s4_park_edges", k, 3);
        check_val("s4_park_clk",   {31'd0, bus.clk_out}, 32'd0);
        repeat (5) do_cycle();
        t_mode = 2'd0;
        do_cycle();
        check_val("s4_resume", {31'd0, bus.running}, 32'd1);
        repeat (6) do_cycle();

        // 5: single step, second press during STEP ignored
        t_mode = 2'd2;
        k = 0;
        do begin
            do_cycle();
            k++;
        end while (bus.running !== 1'b0 && k < 20);
        check_val("s5_parked", {31'd0, bus.running}, 32'd0);
        t_btn = 1'b1;
        ticks = 0; runs = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle();
            ticks += bus.tick;
            runs  += bus.running;
        end
        check_val("s5_ticks", ticks, 1);
        check_val("s5_run_cycles", runs, 4);
        t_btn = 1'b0;
        repeat (5) do_cycle();
        t_btn = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle();
            ticks += bus.tick;
        end
        t_btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            ticks += bus.tick;
        end
        check_val("s5_second_press", ticks, 1);

        // 6: tick_cnt wrap and async reset mid-period
        t_mode = 2'd0;
        t_div  = 16'd2;
        apply_reset();
        ticks = 0; k = 0;
        while (ticks < 17 && k < 80) begin
            do_cycle();
            ticks += bus.tick;
            k++;
        end
        check_val("s6_ticks", ticks, 17);
        check_val("s6_wrap", 32'(bus.tick_cnt), 32'd1);
        t_div = 16'd6;
        wait_pos(2, 6);
        apply_reset();
        do_cycle();
        check_val("s6_restart", {31'd0, bus.clk_out}, 32'd1);
        repeat (14) do_cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) t_div = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 59) == 0) t_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  t_btn = ~t_btn;
            if ($urandom_range(0, 499) == 0) apply_reset();
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
